// File: rtl/game_pkg.sv
// Shared types and level constants for the lock-picking game controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PLAY,
        CLEAR,
        WIN,
        LOSE
    } seq_state_t;

    localparam logic [1:0] LVL_EASY = 2'd0;
    localparam logic [1:0] LVL_MED  = 2'd1;
    localparam logic [1:0] LVL_HARD = 2'd2;
    localparam logic [1:0] LVL_LAST = LVL_HARD;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a synchronous level input.
module edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/level_sequencer.sv
// Game controller: sequences easy/medium/hard levels, enforcing a per-level
// time limit and a per-game budget of failed openings.
module level_sequencer
    import game_pkg::*;
#(
    parameter int          HOLD_CYCLES  = 16,
    parameter int          MAX_ATTEMPTS = 5,
    parameter int unsigned TIME_LIMIT   = 32'd1_500_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       gameStart,
    input  logic       openner,
    input  logic [2:0] levelDone,
    output logic [2:0] levelStart,
    output logic [1:0] currLevel,
    output logic [2:0] attemptsLeft,
    output logic       timerExpired,
    output logic       playing,
    output logic       gameWon,
    output logic       gameLost
);

    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0]  ATT_INIT   = 3'(MAX_ATTEMPTS);
    localparam logic [31:0] TIMER_INIT = 32'(TIME_LIMIT - 1);

    seq_state_t  state;
    logic [7:0]  holdCnt;
    logic [31:0] timer;
    logic        startEdge;
    logic        openEdge;
    logic        curDone;

    edge_detect u_start_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .sig   (gameStart),
        .rise  (startEdge)
    );

    edge_detect u_open_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .sig   (openner),
        .rise  (openEdge)
    );

    assign curDone = levelDone[currLevel];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            levelStart   <= '0;
            currLevel    <= LVL_EASY;
            attemptsLeft <= '0;
            timerExpired <= 1'b0;
            holdCnt      <= '0;
            timer        <= '0;
        end else begin
            levelStart <= '0;
            case (state)
                IDLE, WIN, LOSE: begin
                    if (startEdge) begin
                        state        <= START;
                        currLevel    <= LVL_EASY;
                        attemptsLeft <= ATT_INIT;
                        timerExpired <= 1'b0;
                        levelStart   <= 3'b001;
                    end
                end
                START: begin
                    timer   <= TIMER_INIT;
                    holdCnt <= '0;
                    state   <= PLAY;
                end
                PLAY: begin
                    if (timer != '0) begin
                        timer <= timer - 32'd1;
                    end
                    // Hold counter saturates at its terminal value so it never wraps.
                    if (!curDone) begin
                        holdCnt <= '0;
                    end else if (holdCnt != HOLD_LAST) begin
                        holdCnt <= holdCnt + 8'd1;
                    end
                    if (curDone && holdCnt == HOLD_LAST) begin
                        state <= CLEAR;
                    end else if (openEdge) begin
                        if (attemptsLeft == 3'd1) begin
                            attemptsLeft <= '0;
                            state        <= LOSE;
                        end else begin
                            attemptsLeft <= attemptsLeft - 3'd1;
                        end
                    end else if (timer == '0) begin
                        state        <= LOSE;
                        timerExpired <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (currLevel == LVL_LAST) begin
                        state <= WIN;
                    end else begin
                        currLevel  <= currLevel + 2'd1;
                        levelStart <= 3'b001 << (currLevel + 2'd1);
                        state      <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign playing  = (state == START) || (state == PLAY);
    assign gameWon  = (state == WIN);
    assign gameLost = (state == LOSE);

endmodule
